// File: rtl/freq_div_pkg.sv
// Shared types and constants for the two-requester divided-clock scheduler.
package freq_div_pkg;

   localparam int CNT_W_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   localparam logic REQ_0 = 1'b0;
   localparam logic REQ_1 = 1'b1;

endpackage

// File: rtl/freq_div_sched_div_core.sv
// Half-period counter plus toggle flop; tc marks the edge where clk_out toggles.
module div_core
   import freq_div_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] ratio,
   input  logic             en,
   output logic             clk_out,
   output logic             tc
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] ratio_q, ratio_d;
   logic             clk_q, clk_d;

   assign tc      = en && (cnt_q == ratio_q - ONE);
   assign clk_out = clk_q;

   // With en low the counter parks at zero so the next owner starts clean.
   always_comb begin
      cnt_d   = cnt_q;
      ratio_d = ratio_q;
      clk_d   = clk_q;
      if (load) begin
         ratio_d = ratio;
         cnt_d   = '0;
         clk_d   = 1'b0;
      end else if (en) begin
         if (tc) begin
            cnt_d = '0;
            clk_d = ~clk_q;
         end else begin
            cnt_d = cnt_q + ONE;
         end
      end else begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         cnt_q   <= '0;
         ratio_q <= '0;
         clk_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         ratio_q <= ratio_d;
         clk_q   <= clk_d;
      end
   end

endmodule

// File: rtl/freq_div_sched.sv
// Round-robin owner of one programmable clock divider shared by two requesters.
//
// state | meaning
// IDLE  | no owner, clk_out low, arbitrating eligible requests
// RUN   | owner holds the grant, divider counting
// DRAIN | owner released; finish any high phase, then return to IDLE
module freq_div_sched
   import freq_div_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             req0,
   input  logic [CNT_W-1:0] div0,
   input  logic             req1,
   input  logic [CNT_W-1:0] div1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             clk_out,
   output logic             busy,
   output logic             err
);

   state_e state_q, state_d;
   logic   gnt0_q, gnt0_d;
   logic   gnt1_q, gnt1_d;
   logic   busy_q, busy_d;
   logic   err_q, err_d;
   logic   ptr_q, ptr_d;
   logic   owner_q, owner_d;

   logic             elig0, elig1, win1, owner_req;
   logic             load, en, core_tc, core_clk;
   logic [CNT_W-1:0] ratio_sel;

   assign elig0     = req0 && (div0 != '0);
   assign elig1     = req1 && (div1 != '0);
   assign win1      = elig1 && (!elig0 || (ptr_q == REQ_1));
   assign ratio_sel = win1 ? div1 : div0;
   assign owner_req = (owner_q == REQ_1) ? req1 : req0;

   div_core #(.CNT_W(CNT_W)) u_core (
      .clk_in  (clk_in),
      .reset   (reset),
      .load    (load),
      .ratio   (ratio_sel),
      .en      (en),
      .clk_out (core_clk),
      .tc      (core_tc)
   );

   always_comb begin
      state_d = state_q;
      gnt0_d  = gnt0_q;
      gnt1_d  = gnt1_q;
      busy_d  = busy_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      err_d   = 1'b0;
      load    = 1'b0;
      en      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            err_d = (req0 && (div0 == '0)) || (req1 && (div1 == '0));
            if (elig0 || elig1) begin
               state_d = ST_RUN;
               owner_d = win1;
               gnt0_d  = !win1;
               gnt1_d  = win1;
               busy_d  = 1'b1;
               load    = 1'b1;
            end
         end
         ST_RUN: begin
            en = 1'b1;
            if (!owner_req) begin
               state_d = ST_DRAIN;
               gnt0_d  = 1'b0;
               gnt1_d  = 1'b0;
            end
         end
         ST_DRAIN: begin
            // A low phase may be cut; a high phase runs to its terminal count.
            en = core_clk;
            if (!core_clk || core_tc) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               ptr_d   = ~owner_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
            gnt0_d  = 1'b0;
            gnt1_d  = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
         ptr_q   <= REQ_0;
         owner_q <= REQ_0;
      end else begin
         state_q <= state_d;
         gnt0_q  <= gnt0_d;
         gnt1_q  <= gnt1_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
      end
   end

   assign gnt0    = gnt0_q;
   assign gnt1    = gnt1_q;
   assign busy    = busy_q;
   assign err     = err_q;
   assign clk_out = core_clk;

endmodule

// File: tb/tb_freq_div_sched.sv
// Directed bench for freq_div_sched with hand-computed waveforms and grant order.
module tb_freq_div_sched;

   logic       clk_in;
   logic       reset;
   logic       req0, req1;
   logic [7:0] div0, div1;
   logic       gnt0, gnt1, clk_out, busy, err;

   int total = 0;
   int bad   = 0;
   int viol  = 0;

   freq_div_sched #(.CNT_W(8)) dut (
      .clk_in  (clk_in),
      .reset   (reset),
      .req0    (req0),
      .div0    (div0),
      .req1    (req1),
      .div1    (div1),
      .gnt0    (gnt0),
      .gnt1    (gnt1),
      .clk_out (clk_out),
      .busy    (busy),
      .err     (err)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   // Invariants: never two grants, clk_out low whenever not busy.
   always @(negedge clk_in) begin
      if (!reset) begin
         if (gnt0 && gnt1) viol++;
         if (!busy && clk_out) viol++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic cap(input int n, output logic [31:0] v);
      v = '0;
      for (int i = 0; i < n; i++) begin
         step();
         v = {v[30:0], clk_out};
      end
   endtask

   task automatic wait_gnt(input int lim);
      for (int i = 0; i < lim && !(gnt0 || gnt1); i++) step();
   endtask

   task automatic wait_rise(input int lim);
      for (int i = 0; i < lim && !clk_out; i++) step();
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 600 && busy; i++) step();
      chk("idle_reached", {31'd0, busy}, 0);
   endtask

   initial begin
      logic [31:0] v;
      int          who;

      reset = 1'b1;
      req0  = 1'b0;
      req1  = 1'b0;
      div0  = 8'd0;
      div1  = 8'd0;
      step();
      step();
      chk("rst_gnt0", {31'd0, gnt0}, 0);
      chk("rst_gnt1", {31'd0, gnt1}, 0);
      chk("rst_clk",  {31'd0, clk_out}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_err",  {31'd0, err}, 0);
      reset = 1'b0;
      step();

      // single requester, ratio 3
      req0 = 1'b1;
      div0 = 8'd3;
      step();
      chk("t1_gnt0", {31'd0, gnt0}, 1);
      chk("t1_busy", {31'd0, busy}, 1);
      chk("t1_clk0", {31'd0, clk_out}, 0);
      cap(9, v);
      chk("t1_wave", v, 32'b001110001);
      req0 = 1'b0;
      step();
      chk("t1_gnt_drop", {31'd0, gnt0}, 0);
      chk("t1_busy_drain", {31'd0, busy}, 1);
      chk("t1_clk_hold", {31'd0, clk_out}, 1);
      cap(2, v);
      chk("t1_drain_wave", v, 32'b10);
      chk("t1_busy_end", {31'd0, busy}, 0);

      // simultaneous requests out of reset
      reset = 1'b1;
      req0  = 1'b1;
      req1  = 1'b1;
      div0  = 8'd2;
      div1  = 8'd5;
      #2;
      reset = 1'b0;
      step();
      chk("t2_gnt0", {31'd0, gnt0}, 1);
      chk("t2_gnt1", {31'd0, gnt1}, 0);
      cap(8, v);
      chk("t2_wave0", v, 32'b01100110);
      req0 = 1'b0;
      step();
      chk("t2_drain_g0", {31'd0, gnt0}, 0);
      chk("t2_drain_g1", {31'd0, gnt1}, 0);
      chk("t2_drain_busy", {31'd0, busy}, 1);
      step();
      chk("t2_idle_busy", {31'd0, busy}, 0);
      chk("t2_idle_g1", {31'd0, gnt1}, 0);
      step();
      chk("t2_gnt1", {31'd0, gnt1}, 1);
      cap(10, v);
      chk("t2_wave1", v, 32'b0000111110);
      chk("t2_err", {31'd0, err}, 0);
      req1 = 1'b0;
      wait_idle();

      // round-robin with both held; owner re-raises during DRAIN
      div0 = 8'd1;
      div1 = 8'd2;
      req0 = 1'b1;
      req1 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wait_gnt(50);
         chk("rr_gnt_seen", {31'd0, gnt0 | gnt1}, 1);
         who = gnt1 ? 1 : 0;
         chk("rr_owner", who, k % 2);
         if (k == 0) begin
            cap(4, v);
            chk("rr_ratio1_wave", v, 32'b1010);
            repeat (4) step();
         end else begin
            repeat (8 * (who + 1)) step();
         end
         if (who == 1) req1 = 1'b0;
         else          req0 = 1'b0;
         step();
         req0 = 1'b1;
         req1 = 1'b1;
      end
      req0 = 1'b0;
      req1 = 1'b0;
      wait_idle();

      // glitch-free stop mid high phase, ratio 4
      div0 = 8'd4;
      req0 = 1'b1;
      wait_gnt(10);
      chk("t4_gnt0", {31'd0, gnt0}, 1);
      wait_rise(20);
      chk("t4_rise", {31'd0, clk_out}, 1);
      req0 = 1'b0;
      step();
      chk("t4_gnt_drop", {31'd0, gnt0}, 0);
      chk("t4_busy", {31'd0, busy}, 1);
      chk("t4_clk_hi", {31'd0, clk_out}, 1);
      cap(4, v);
      chk("t4_wave", v, 32'b1100);
      chk("t4_busy_end", {31'd0, busy}, 0);

      // zero ratio is never granted and raises err
      req0 = 1'b0;
      div0 = 8'd0;
      div1 = 8'd0;
      req1 = 1'b1;
      step();
      chk("t5_err", {31'd0, err}, 1);
      chk("t5_nogrant", {31'd0, gnt1}, 0);
      chk("t5_busy", {31'd0, busy}, 0);
      step();
      step();
      chk("t5_err_hold", {31'd0, err}, 1);
      chk("t5_nogrant2", {31'd0, gnt1}, 0);
      div1 = 8'd7;
      step();
      chk("t5_err_clr", {31'd0, err}, 0);
      chk("t5_gnt1", {31'd0, gnt1}, 1);
      req1 = 1'b0;
      wait_idle();

      // async reset while clk_out is high
      div0 = 8'd6;
      req0 = 1'b1;
      wait_gnt(10);
      wait_rise(20);
      chk("t6_rise", {31'd0, clk_out}, 1);
      step();
      step();
      reset = 1'b1;
      #1;
      chk("t6_clk", {31'd0, clk_out}, 0);
      chk("t6_gnt0", {31'd0, gnt0}, 0);
      chk("t6_busy", {31'd0, busy}, 0);
      chk("t6_err", {31'd0, err}, 0);
      req1 = 1'b1;
      div1 = 8'd3;
      #1;
      reset = 1'b0;
      step();
      chk("t6_regnt0", {31'd0, gnt0}, 1);
      chk("t6_regnt1", {31'd0, gnt1}, 0);
      req0 = 1'b0;
      req1 = 1'b0;
      wait_idle();

      chk("invariants", viol, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
